// File: rtl/prg_loader_if.sv
// Bundle of the ioctl download stream, the RAM write port and loader status.
// master drives the ioctl stream and acknowledges writes; slave is the loader.
interface prg_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;
    logic        dma_ready;
    logic        busy;
    logic [15:0] load_start;
    logic [15:0] load_end;
    logic        error;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ready,
        input  ioctl_wait, dma_addr, dma_dout, dma_we, busy, load_start, load_end, error
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ready,
        output ioctl_wait, dma_addr, dma_dout, dma_we, busy, load_start, load_end, error
    );
endinterface

// File: rtl/prg_loader.sv
// PRG loader: strips the 2-byte load-address header and writes the payload into RAM,
// then patches the BASIC VARTAB/ARYTAB/STREND pointers; each write is held until accepted.
module prg_loader #(
    parameter logic [7:0]  INDEX      = 8'h41,
    parameter logic [15:0] PTR_BASE   = 16'h002A,
    parameter bit          PATCH_PTRS = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    prg_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRPEND, PATCH, DONE} state_t;

    state_t      state, state_d;
    logic [15:0] wr_addr, wr_addr_d;
    logic [7:0]  wr_data, wr_data_d;
    logic [15:0] load_start, load_start_d;
    logic [15:0] load_end, load_end_d;
    logic        error, error_d;
    logic        dl_q;
    logic        end_req, end_req_d;
    logic [2:0]  patch_idx, patch_idx_d;

    logic        accept;
    logic        dl_fall;
    logic        dma_we;
    logic        written;
    logic [24:0] target;
    state_t      end_state;

    assign accept    = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == INDEX);
    assign dl_fall   = dl_q && !bus.ioctl_download;
    assign dma_we    = (state == WRPEND) || (state == PATCH);
    assign written   = dma_we && bus.dma_ready;
    // Full-width sum so any file offset past 64 KiB is caught as an overflow.
    assign target    = 25'(load_start) + bus.ioctl_addr - 25'd2;
    assign end_state = PATCH_PTRS ? PATCH : DONE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            load_start <= '0;
            load_end   <= '0;
            error      <= 1'b0;
            dl_q       <= 1'b0;
            end_req    <= 1'b0;
            patch_idx  <= '0;
        end else begin
            state      <= state_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            load_start <= load_start_d;
            load_end   <= load_end_d;
            error      <= error_d;
            dl_q       <= bus.ioctl_download;
            end_req    <= end_req_d;
            patch_idx  <= patch_idx_d;
        end
    end

    always_comb begin
        state_d      = state;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        load_start_d = load_start;
        load_end_d   = load_end;
        error_d      = error;
        end_req_d    = end_req;
        patch_idx_d  = patch_idx;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = HDR;
                    error_d = 1'b0;
                    if (bus.ioctl_addr == 25'd0) begin
                        load_start_d[7:0] = bus.ioctl_dout;
                    end else if (bus.ioctl_addr == 25'd1) begin
                        load_start_d[15:8] = bus.ioctl_dout;
                        state_d            = DATA;
                    end
                end
            end
            HDR: begin
                if (dl_fall) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (accept) begin
                    if (bus.ioctl_addr == 25'd0) begin
                        load_start_d[7:0] = bus.ioctl_dout;
                    end else if (bus.ioctl_addr == 25'd1) begin
                        load_start_d[15:8] = bus.ioctl_dout;
                        state_d            = DATA;
                    end
                end
            end
            DATA: begin
                if (dl_fall) begin
                    state_d     = end_state;
                    patch_idx_d = '0;
                end else if (accept && (bus.ioctl_addr >= 25'd2)) begin
                    if (target[24:16] != '0) begin
                        error_d = 1'b1;
                    end else begin
                        wr_addr_d = target[15:0];
                        wr_data_d = bus.ioctl_dout;
                        state_d   = WRPEND;
                    end
                end
            end
            WRPEND: begin
                if (accept) begin
                    error_d = 1'b1;
                end
                if (dl_fall) begin
                    end_req_d = 1'b1;
                end
                if (written) begin
                    load_end_d = wr_addr + 16'd1;
                    // A download that ended while this write was pending finishes here.
                    if (end_req || dl_fall) begin
                        state_d     = end_state;
                        end_req_d   = 1'b0;
                        patch_idx_d = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            PATCH: begin
                if (written) begin
                    if (patch_idx == 3'd5) begin
                        state_d = DONE;
                    end else begin
                        patch_idx_d = patch_idx + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer pairs are little-endian copies of load_end at PTR_BASE+0..+5.
    assign bus.dma_addr   = (state == PATCH) ? (PTR_BASE + 16'(patch_idx)) : wr_addr;
    assign bus.dma_dout   = (state == PATCH) ? (patch_idx[0] ? load_end[15:8] : load_end[7:0])
                                             : wr_data;
    assign bus.dma_we     = dma_we;
    assign bus.ioctl_wait = dma_we;
    assign bus.busy       = (state != IDLE);
    assign bus.load_start = load_start;
    assign bus.load_end   = load_end;
    assign bus.error      = error;
endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: header parsing, held writes, overflow, short file,
// reset during pointer patching and foreign-index strobes.
module tb_prg_loader;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prg_loader_if bus ();

    prg_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    int          log_n = 0;

    // Record every accepted RAM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.dma_we === 1'b1 && bus.dma_ready === 1'b1 && log_n < 64) begin
            log_addr[log_n] = bus.dma_addr;
            log_data[log_n] = bus.dma_dout;
            log_n = log_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (bus.ioctl_wait === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),       32'd0);
        chk({tag, "_we"},    32'(bus.dma_we),     32'd0);
        chk({tag, "_wait"},  32'(bus.ioctl_wait), 32'd0);
        chk({tag, "_err"},   32'(bus.error),      32'd0);
        chk({tag, "_addr"},  32'(bus.dma_addr),   32'd0);
        chk({tag, "_dout"},  32'(bus.dma_dout),   32'd0);
        chk({tag, "_start"}, 32'(bus.load_start), 32'd0);
        chk({tag, "_end"},   32'(bus.load_end),   32'd0);
    endtask

    initial begin
        int base;
        int n;
        logic [15:0] ea [0:7];
        logic [7:0]  ed [0:7];
        ea = '{16'h0401, 16'h0402, 16'h002A, 16'h002B, 16'h002C, 16'h002D, 16'h002E, 16'h002F};
        ed = '{8'hAA, 8'hBB, 8'h03, 8'h04, 8'h03, 8'h04, 8'h03, 8'h04};

        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h41;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.dma_ready      = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        reset_n = 1'b1;
        tick();

        // Basic load 01 04 AA BB, ready always high.
        base = log_n;
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'h01);
        send(25'd1, 8'h04);
        chk("t1_start", 32'(bus.load_start), 32'h0401);
        chk("t1_hdr_we", 32'(bus.dma_we), 32'd0);
        chk("t1_hdr_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send(25'd2, 8'hAA);
        chk("t1_we", 32'(bus.dma_we), 32'd1);
        chk("t1_addr", 32'(bus.dma_addr), 32'h0401);
        chk("t1_dout", 32'(bus.dma_dout), 32'hAA);
        chk("t1_wait", 32'(bus.ioctl_wait), 32'd1);
        send(25'd3, 8'hBB);
        bus.ioctl_download = 1'b0;
        wait_idle();
        chk("t1_count", 32'(log_n - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_wr%0d_addr", i), 32'(log_addr[base + i]), 32'(ea[i]));
            chk($sformatf("t1_wr%0d_data", i), 32'(log_data[base + i]), 32'(ed[i]));
        end
        chk("t1_end", 32'(bus.load_end), 32'h0403);
        chk("t1_err", 32'(bus.error), 32'd0);

        // Write held for five cycles with ready low.
        base = log_n;
        bus.dma_ready = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'h01);
        send(25'd1, 8'h04);
        send(25'd2, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_we_c%0d", i), 32'(bus.dma_we), 32'd1);
            chk($sformatf("t2_wait_c%0d", i), 32'(bus.ioctl_wait), 32'd1);
            chk($sformatf("t2_addr_c%0d", i), 32'(bus.dma_addr), 32'h0401);
            tick();
        end
        bus.dma_ready = 1'b1;
        chk("t2_we_acc", 32'(bus.dma_we), 32'd1);
        tick();
        chk("t2_we_after", 32'(bus.dma_we), 32'd0);
        chk("t2_wait_after", 32'(bus.ioctl_wait), 32'd0);
        chk("t2_end", 32'(bus.load_end), 32'h0402);
        bus.ioctl_download = 1'b0;
        wait_idle();
        chk("t2_count", 32'(log_n - base), 32'd7);
        chk("t2_wr0_addr", 32'(log_addr[base]), 32'h0401);
        chk("t2_wr0_data", 32'(log_data[base]), 32'hAA);

        // Header FFFF: one write at FFFF, remaining bytes overflow.
        base = log_n;
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'hFF);
        send(25'd1, 8'hFF);
        send(25'd2, 8'h11);
        send(25'd3, 8'h22);
        chk("t3_ovf_we", 32'(bus.dma_we), 32'd0);
        chk("t3_ovf_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("t3_ovf_err", 32'(bus.error), 32'd1);
        send(25'd4, 8'h33);
        bus.ioctl_download = 1'b0;
        wait_idle();
        chk("t3_count", 32'(log_n - base), 32'd7);
        chk("t3_wr0_addr", 32'(log_addr[base]), 32'hFFFF);
        chk("t3_wr0_data", 32'(log_data[base]), 32'h11);
        chk("t3_wr1_addr", 32'(log_addr[base + 1]), 32'h002A);
        chk("t3_wr1_data", 32'(log_data[base + 1]), 32'h00);
        chk("t3_end", 32'(bus.load_end), 32'h0000);
        chk("t3_err", 32'(bus.error), 32'd1);

        // Single header byte: no writes, error set, error cleared on header entry.
        base = log_n;
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'h01);
        chk("t4_err_clr", 32'(bus.error), 32'd0);
        bus.ioctl_download = 1'b0;
        wait_idle();
        chk("t4_count", 32'(log_n - base), 32'd0);
        chk("t4_err", 32'(bus.error), 32'd1);

        // Reset during the third pointer write.
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'h01);
        send(25'd1, 8'h04);
        send(25'd2, 8'hAA);
        bus.ioctl_download = 1'b0;
        n = 0;
        while (!(bus.dma_we === 1'b1 && bus.dma_addr === 16'h002C) && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reach_ptr3", 32'(bus.dma_addr), 32'h002C);
        reset_n = 1'b0;
        tick();
        chk_reset("t5_rst");
        reset_n = 1'b1;
        base = log_n;
        repeat (10) tick();
        chk("t5_no_write", 32'(log_n - base), 32'd0);

        // Strobes for another download type are ignored.
        base = log_n;
        bus.ioctl_index = 8'h01;
        bus.ioctl_download = 1'b1;
        tick();
        send(25'd0, 8'h01);
        chk("t6_busy0", 32'(bus.busy), 32'd0);
        send(25'd1, 8'h04);
        send(25'd2, 8'hAA);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        bus.ioctl_download = 1'b0;
        repeat (3) tick();
        chk("t6_count", 32'(log_n - base), 32'd0);
        bus.ioctl_index = 8'h41;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
